// File: rtl/exhaustive_stim_sequencer.sv
// Exhaustive stimulus sequencer: walks every WIDTH-bit pattern in ascending
// order, holds each for SETTLE cycles, captures the DUT response into a
// signature vector and flags a mismatch against the golden signature.
module exhaustive_stim_sequencer #(
  parameter int WIDTH  = 3,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1
) (
  input  logic                        CK,
  input  logic                        reset,
  input  logic                        start,
  input  logic [OUT_W-1:0]            dut_out,
  input  logic [OUT_W*(2**WIDTH)-1:0] golden,
  output logic [WIDTH-1:0]            pat_out,
  output logic                        busy,
  output logic                        done,
  output logic                        sample_valid,
  output logic [WIDTH-1:0]            sample_pattern,
  output logic [OUT_W-1:0]            sample_data,
  output logic [OUT_W*(2**WIDTH)-1:0] response,
  output logic                        mismatch
);

  localparam int NPAT   = 2**WIDTH;
  localparam int RESP_W = OUT_W * NPAT;
  localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] PAT_LAST = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  settle_cnt;
  logic              accept;
  logic              capture;
  logic [RESP_W-1:0] resp_upd;

  // Next-state decode plus the signature as it would look after this capture.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    resp_upd = response;
    resp_upd[int'(pat_out)*OUT_W +: OUT_W] = dut_out;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (settle_cnt == '0) begin
          capture = 1'b1;
          if (pat_out == PAT_LAST) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CK) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Pattern counter, settle timer, capture registers and end-of-run flags.
  always_ff @(posedge CK) begin
    if (reset) begin
      pat_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      sample_valid   <= 1'b0;
      sample_pattern <= '0;
      sample_data    <= '0;
      response       <= '0;
      mismatch       <= 1'b0;
      settle_cnt     <= '0;
    end else begin
      sample_valid <= 1'b0;
      done         <= 1'b0;
      if (accept) begin
        busy       <= 1'b1;
        pat_out    <= '0;
        settle_cnt <= CNT_LOAD;
        response   <= '0;
        mismatch   <= 1'b0;
      end else if (state_q == RUN) begin
        if (capture) begin
          response       <= resp_upd;
          mismatch       <= (resp_upd != golden);
          sample_valid   <= 1'b1;
          sample_pattern <= pat_out;
          sample_data    <= dut_out;
          if (pat_out == PAT_LAST) begin
            // Wrap back to pattern 0 only when the run finishes.
            pat_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            pat_out    <= pat_out + 1'b1;
            settle_cnt <= CNT_LOAD;
          end
        end else begin
          settle_cnt <= settle_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_exhaustive_stim_sequencer.sv
// Scoreboard bench for exhaustive_stim_sequencer: a cycle-level reference of
// run timing feeds expected captures/done records into queues, a negedge
// monitor pops and compares them. A second instance with SETTLE=3 driving a
// registered DUT covers multi-cycle settling.
module tb_exhaustive_stim_sequencer;

  localparam int S1 = 1;

  logic       CK = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tt = 8'h96;
  logic [7:0] golden = 8'h96;
  logic       dut_out;
  logic [2:0] pat_out, sample_pattern;
  logic       busy, done, sample_valid, sample_data, mismatch;
  logic [7:0] response;

  logic       start3 = 1'b0;
  logic       dut_out3;
  logic [7:0] golden3 = 8'h96;
  logic [2:0] pat_out3, sample_pattern3;
  logic       busy3, done3, sample_valid3, sample_data3, mismatch3;
  logic [7:0] response3;

  always #5 CK = ~CK;

  // Combinational DUT: truth table lookup.
  assign dut_out = tt[pat_out];

  // Registered DUT: parity of the pattern, one cycle late.
  always @(posedge CK) dut_out3 <= ^pat_out3;

  exhaustive_stim_sequencer #(.WIDTH(3), .OUT_W(1), .SETTLE(S1)) u_dut (
    .CK(CK), .reset(reset), .start(start), .dut_out(dut_out), .golden(golden),
    .pat_out(pat_out), .busy(busy), .done(done), .sample_valid(sample_valid),
    .sample_pattern(sample_pattern), .sample_data(sample_data),
    .response(response), .mismatch(mismatch));

  exhaustive_stim_sequencer #(.WIDTH(3), .OUT_W(1), .SETTLE(3)) u_dut3 (
    .CK(CK), .reset(reset), .start(start3), .dut_out(dut_out3), .golden(golden3),
    .pat_out(pat_out3), .busy(busy3), .done(done3), .sample_valid(sample_valid3),
    .sample_pattern(sample_pattern3), .sample_data(sample_data3),
    .response(response3), .mismatch(mismatch3));

  typedef struct { int cyc; logic [2:0] pat; logic data; } samp_t;
  typedef struct { int cyc; logic [7:0] resp; logic mis; } done_t;

  samp_t sq[$];
  done_t dq[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   next_free = 0;
  int   run_lo = 0;
  int   run_hi = 0;
  int   n_done = 0;
  int   n_samp = 0;
  bit   mon_en = 1'b0;
  logic [7:0] held_resp = 8'h00;
  logic       held_mis = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a run accepted at edge c0 captures pattern k at edge c0+(k+1)*S,
  // pulses done after edge c0+8*S, and the next run can start at c0+8*S+2.
  always @(posedge CK) begin
    cyc = cyc + 1;
    if (reset) begin
      sq.delete();
      dq.delete();
      next_free = cyc + 1;
      run_lo    = 0;
      run_hi    = 0;
      held_resp = 8'h00;
      held_mis  = 1'b0;
    end else if (start && cyc >= next_free) begin
      for (int k = 0; k < 8; k++) begin
        samp_t s;
        s.cyc  = cyc + (k + 1) * S1;
        s.pat  = 3'(k);
        s.data = tt[k];
        sq.push_back(s);
      end
      begin
        done_t d;
        d.cyc  = cyc + 8 * S1;
        d.resp = tt;
        d.mis  = (tt != golden);
        dq.push_back(d);
      end
      run_lo    = cyc;
      run_hi    = cyc + 8 * S1;
      next_free = cyc + 8 * S1 + 2;
    end
  end

  // Monitor: compare captures, done records and per-cycle control outputs.
  always @(negedge CK) begin
    if (mon_en) begin
      logic       exp_busy;
      logic [2:0] exp_pat;
      exp_busy = (cyc >= run_lo) && (cyc < run_hi);
      exp_pat  = exp_busy ? 3'((cyc - run_lo) / S1) : 3'd0;
      check("busy", 32'(busy), 32'(exp_busy));
      check("pat_out", 32'(pat_out), 32'(exp_pat));

      if (sample_valid) begin
        n_samp++;
        if (sq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_sample: got pattern %0d, expected no capture (cycle %0d)", sample_pattern, cyc);
        end else begin
          samp_t s;
          s = sq.pop_front();
          check("sample_cycle", 32'(cyc), 32'(s.cyc));
          check("sample_pattern", 32'(sample_pattern), 32'(s.pat));
          check("sample_data", 32'(sample_data), 32'(s.data));
        end
      end else if (sq.size() > 0 && sq[0].cyc <= cyc) begin
        total++; bad++;
        $display("FAIL missing_sample: got none, expected pattern %0d at cycle %0d", sq[0].pat, sq[0].cyc);
        void'(sq.pop_front());
      end

      if (done) begin
        n_done++;
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done, expected none (cycle %0d)", cyc);
        end else begin
          done_t d;
          d = dq.pop_front();
          check("done_cycle", 32'(cyc), 32'(d.cyc));
          check("done_response", 32'(response), 32'(d.resp));
          check("done_mismatch", 32'(mismatch), 32'(d.mis));
          held_resp = d.resp;
          held_mis  = d.mis;
        end
      end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        total++; bad++;
        $display("FAIL missing_done: got none, expected done at cycle %0d", dq[0].cyc);
        void'(dq.pop_front());
      end

      if (!exp_busy) begin
        check("held_response", 32'(response), 32'(held_resp));
        check("held_mismatch", 32'(mismatch), 32'(held_mis));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CK);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sq.size() != 0 || dq.size() != 0 || busy || done) && n < 300) begin
      @(negedge CK);
      n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", n);
    end
    repeat (2) @(negedge CK);
  endtask

  task automatic check_reset_outputs();
    check("rst_pat_out", 32'(pat_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sample_valid", 32'(sample_valid), 0);
    check("rst_sample_pattern", 32'(sample_pattern), 0);
    check("rst_sample_data", 32'(sample_data), 0);
    check("rst_response", 32'(response), 0);
    check("rst_mismatch", 32'(mismatch), 0);
  endtask

  task automatic run_s3();
    int nv;
    int dn;
    nv = 0;
    dn = -1;
    start3 = 1'b1;
    @(negedge CK);
    start3 = 1'b0;
    for (int n = 0; n <= 30; n++) begin
      if (n > 0) @(negedge CK);
      if (n < 24) begin
        check("s3_pat_out", 32'(pat_out3), 32'(n / 3));
        check("s3_busy", 32'(busy3), 1);
      end
      if (sample_valid3) begin
        nv++;
        check("s3_sample_cycle", 32'(n), 32'(3 * (int'(sample_pattern3) + 1)));
        check("s3_sample_data", 32'(sample_data3), 32'(^sample_pattern3));
      end
      if (done3) begin
        dn = n;
        check("s3_response", 32'(response3), 32'h96);
        check("s3_mismatch", 32'(mismatch3), 0);
        check("s3_busy_at_done", 32'(busy3), 0);
      end
    end
    check("s3_done_cycle", 32'(dn), 24);
    check("s3_sample_count", 32'(nv), 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int s0;
    @(negedge CK);
    mon_en = 1'b1;
    @(negedge CK);
    check_reset_outputs();
    reset = 1'b0;
    repeat (2) @(negedge CK);

    // XOR DUT with matching golden.
    tt = 8'h96; golden = 8'h96;
    pulse_start();
    wait_idle();

    // Golden off by one bit: mismatch set and held into IDLE.
    golden = 8'h97;
    pulse_start();
    wait_idle();
    repeat (3) @(negedge CK);
    check("held_mis_idle", 32'(mismatch), 1);
    pulse_start();
    check("start_clears_mismatch", 32'(mismatch), 0);
    check("start_clears_response", 32'(response), 0);
    wait_idle();

    // Extra start pulses during a run are ignored.
    golden = 8'h96;
    d0 = n_done; s0 = n_samp;
    pulse_start();
    @(negedge CK);
    pulse_start();
    repeat (2) @(negedge CK);
    pulse_start();
    wait_idle();
    check("ignored_start_dones", 32'(n_done - d0), 1);
    check("ignored_start_samples", 32'(n_samp - s0), 8);

    // Reset in the middle of a run.
    d0 = n_done;
    pulse_start();
    begin
      int n;
      n = 0;
      while (pat_out != 3'd4 && n < 20) begin
        @(negedge CK);
        n++;
      end
      check("reach_pat4", 32'(pat_out), 4);
    end
    reset = 1'b1;
    @(negedge CK);
    reset = 1'b0;
    check_reset_outputs();
    repeat (12) @(negedge CK);
    check("no_done_after_reset", 32'(n_done - d0), 0);
    pulse_start();
    wait_idle();
    check("run_after_reset", 32'(response), 32'h96);

    // Randomised truth tables and goldens.
    for (int r = 0; r < 6; r++) begin
      tt = 8'($urandom);
      golden = ($urandom_range(0, 1) == 1) ? tt : 8'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge CK);
      pulse_start();
      wait_idle();
    end

    // start held high: three back-to-back runs.
    tt = 8'h96; golden = 8'h96;
    d0 = n_done;
    start = 1'b1;
    repeat (29) @(negedge CK);
    start = 1'b0;
    wait_idle();
    check("held_start_runs", 32'(n_done - d0), 3);

    // Multi-cycle settle with a registered DUT.
    run_s3();
    repeat (3) @(negedge CK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
